// File: rtl/csr_file_if.sv
// CSR access bus between the core (master) and the machine-mode CSR file (slave).
// Carries the trap port, the Zicsr instruction port and the retire pulse.
interface csr_file_if;
    logic        trap_done;
    logic [11:0] csr_trap_address;
    logic [31:0] csr_trap_write_data;
    logic [11:0] csr_read_address;
    logic        csr_write_enable;
    logic [11:0] csr_write_address;
    logic [31:0] csr_write_data;
    logic        instruction_retired;
    logic [31:0] csr_read_data;
    logic        csr_illegal;
    logic        write_conflict;

    modport master (
        output trap_done, csr_trap_address, csr_trap_write_data,
               csr_read_address, csr_write_enable, csr_write_address,
               csr_write_data, instruction_retired,
        input  csr_read_data, csr_illegal, write_conflict
    );

    modport slave (
        input  trap_done, csr_trap_address, csr_trap_write_data,
               csr_read_address, csr_write_enable, csr_write_address,
               csr_write_data, instruction_retired,
        output csr_read_data, csr_illegal, write_conflict
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core: Zicsr instruction port, trap port, 64-bit counters.
// Define CSR_COUNTERS_EN to build mcycle/minstret and their user-level read-only shadows.
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MIMPID      = 32'h0000_0001
) (
    input  logic      clk,
    input  logic      rst,
    csr_file_if.slave bus
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic [31:0] mie_reg;
    logic [31:2] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:2] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic        write_conflict_reg;

    logic [11:0] read_sel;
    logic        instr_fire;
    logic        trap_fire;
    logic [31:0] read_data_next;
    logic        implemented_next;
    logic        write_ok_next;

    assign read_sel   = bus.trap_done ? bus.csr_read_address : bus.csr_trap_address;
    assign trap_fire  = ~bus.trap_done;
    assign instr_fire = bus.csr_write_enable & bus.trap_done;

`ifdef CSR_COUNTERS_EN
    // Index 0 is mcycle, index 1 is minstret.
    logic [1:0][63:0] count_val;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_counter
        localparam logic [11:0] LO_ADDR = 12'hB00 + 12'(2 * gi);
        localparam logic [11:0] HI_ADDR = 12'hB80 + 12'(2 * gi);
        logic [63:0] count_reg;
        logic        step;

        assign step = (gi == 0) ? 1'b1 : bus.instruction_retired;

        // A write to either half freezes the whole counter for that edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                count_reg <= 64'd0;
            else if (instr_fire && bus.csr_write_address == LO_ADDR)
                count_reg[31:0] <= bus.csr_write_data;
            else if (instr_fire && bus.csr_write_address == HI_ADDR)
                count_reg[63:32] <= bus.csr_write_data;
            else if (step)
                count_reg <= count_reg + 64'd1;
        end

        assign count_val[gi] = count_reg;
    end
`else
    logic unused_retired;
    assign unused_retired = bus.instruction_retired;
`endif

    always_comb begin
        read_data_next   = 32'd0;
        implemented_next = 1'b1;
        case (read_sel)
            A_MSTATUS:   read_data_next = {19'd0, 2'b11, 3'd0, mstatus_mpie_reg, 3'd0, mstatus_mie_reg, 3'd0};
            A_MISA:      read_data_next = MISA_VALUE;
            A_MIE:       read_data_next = mie_reg;
            A_MTVEC:     read_data_next = {mtvec_reg, 2'b00};
            A_MSCRATCH:  read_data_next = mscratch_reg;
            A_MEPC:      read_data_next = {mepc_reg, 2'b00};
            A_MCAUSE:    read_data_next = mcause_reg;
            A_MTVAL:     read_data_next = mtval_reg;
            A_MIP:       read_data_next = 32'd0;
            A_MVENDORID: read_data_next = 32'd0;
            A_MARCHID:   read_data_next = 32'd0;
            A_MIMPID:    read_data_next = MIMPID;
            A_MHARTID:   read_data_next = HART_ID;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: read_data_next = count_val[0][31:0];
            12'hB80, 12'hC80: read_data_next = count_val[0][63:32];
            12'hB02, 12'hC02: read_data_next = count_val[1][31:0];
            12'hB82, 12'hC82: read_data_next = count_val[1][63:32];
`endif
            default:     implemented_next = 1'b0;
        endcase
    end

    // Addresses the instruction port may modify; everything else is read-only or absent.
    always_comb begin
        write_ok_next = 1'b0;
        case (bus.csr_write_address)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
            A_MEPC, A_MCAUSE, A_MTVAL:    write_ok_next = 1'b1;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hB80, 12'hB02, 12'hB82: write_ok_next = 1'b1;
`endif
            default:                      write_ok_next = 1'b0;
        endcase
    end

    assign bus.csr_read_data  = read_data_next;
    assign bus.csr_illegal    = ~implemented_next | (instr_fire & ~write_ok_next);
    assign bus.write_conflict = write_conflict_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= 32'd0;
            mtvec_reg        <= MTVEC_RESET[31:2];
            mscratch_reg     <= 32'd0;
            mepc_reg         <= 30'd0;
            mcause_reg       <= 32'd0;
            mtval_reg        <= 32'd0;
        end else if (trap_fire) begin
            // The trap port can only update mepc and mcause; the instruction port is locked out.
            case (bus.csr_trap_address)
                A_MEPC:   mepc_reg   <= bus.csr_trap_write_data[31:2];
                A_MCAUSE: mcause_reg <= bus.csr_trap_write_data;
                default:  ;
            endcase
        end else if (bus.csr_write_enable) begin
            case (bus.csr_write_address)
                A_MSTATUS: begin
                    mstatus_mie_reg  <= bus.csr_write_data[3];
                    mstatus_mpie_reg <= bus.csr_write_data[7];
                end
                A_MIE:      mie_reg      <= bus.csr_write_data;
                A_MTVEC:    mtvec_reg    <= bus.csr_write_data[31:2];
                A_MSCRATCH: mscratch_reg <= bus.csr_write_data;
                A_MEPC:     mepc_reg     <= bus.csr_write_data[31:2];
                A_MCAUSE:   mcause_reg   <= bus.csr_write_data;
                A_MTVAL:    mtval_reg    <= bus.csr_write_data;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            write_conflict_reg <= 1'b0;
        else
            write_conflict_reg <= ~bus.trap_done & bus.csr_write_enable;
    end
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: expected values are queued when stimulus is applied and
// popped when the corresponding DUT output is sampled.
module tb_csr_file;
    localparam logic [31:0] P_MTVEC_RESET = 32'h8000_0103;
    localparam logic [31:0] P_HART_ID     = 32'd3;
    localparam logic [31:0] MTVEC_EXP     = 32'h8000_0100;

    logic clk;
    logic rst;
    csr_file_if bus ();

    csr_file #(
        .HART_ID     (P_HART_ID),
        .MTVEC_RESET (P_MTVEC_RESET),
        .MIMPID      (32'h0000_0001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run;
    int   tests_failed;

    task automatic expect_v(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] observed);
        exp_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: observed %h required an expectation", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.value) else begin
                tests_failed++;
                $error("FAIL %s: observed %h expected %h", e.tag, observed, e.value);
            end
            $display("[TB] %s observed %h expected %h", e.tag, observed, e.value);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.trap_done           = 1'b1;
        bus.csr_trap_address    = 12'h000;
        bus.csr_trap_write_data = 32'd0;
        bus.csr_write_enable    = 1'b0;
        bus.csr_write_address   = 12'h000;
        bus.csr_write_data      = 32'd0;
    endtask

    task automatic read_chk(input string tag, input logic [11:0] addr,
                            input logic [31:0] data, input logic ill);
        bus.trap_done        = 1'b1;
        bus.csr_write_enable = 1'b0;
        bus.csr_read_address = addr;
        #1;
        expect_v(tag, data);
        compare(bus.csr_read_data);
        expect_v({tag, "_ill"}, {31'd0, ill});
        compare({31'd0, bus.csr_illegal});
    endtask

    task automatic instr_write(input logic [11:0] addr, input logic [31:0] data);
        bus.trap_done         = 1'b1;
        bus.csr_write_enable  = 1'b1;
        bus.csr_write_address = addr;
        bus.csr_write_data    = data;
        tick();
        bus.csr_write_enable  = 1'b0;
    endtask

    task automatic trap_write(input logic [11:0] addr, input logic [31:0] data);
        bus.trap_done           = 1'b0;
        bus.csr_write_enable    = 1'b0;
        bus.csr_trap_address    = addr;
        bus.csr_trap_write_data = data;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        bus.instruction_retired = 1'b0;
        bus.csr_read_address    = 12'h000;
        idle();
        #2;

        // Reset contents, visible while reset is still held
        read_chk("rst_mtvec", 12'h305, MTVEC_EXP, 1'b0);
        read_chk("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);
        read_chk("rst_mepc", 12'h341, 32'd0, 1'b0);
        expect_v("rst_wc", 32'd0);
        compare({31'd0, bus.write_conflict});

        @(negedge clk);
        rst = 1'b0;
        tick();

        // Trap sequence, read back through the trap-selected address
        trap_write(12'h341, 32'h0000_0084);
        expect_v("trap_mepc", 32'h0000_0084);
        compare(bus.csr_read_data);
        trap_write(12'h342, 32'd11);
        expect_v("trap_mcause", 32'd11);
        compare(bus.csr_read_data);
        trap_write(12'h305, 32'd0);
        expect_v("trap_mtvec_kept", MTVEC_EXP);
        compare(bus.csr_read_data);
        expect_v("trap_mtvec_ill", 32'd0);
        compare({31'd0, bus.csr_illegal});
        idle();
        read_chk("instr_read_mepc", 12'h341, 32'h0000_0084, 1'b0);

        // Conflict: trap port wins, instruction write dropped, one-cycle pulse
        bus.trap_done           = 1'b0;
        bus.csr_trap_address    = 12'h341;
        bus.csr_trap_write_data = 32'h0000_0100;
        bus.csr_write_enable    = 1'b1;
        bus.csr_write_address   = 12'h340;
        bus.csr_write_data      = 32'hDEAD_BEEF;
        expect_v("conflict_pre", 32'd0);
        compare({31'd0, bus.write_conflict});
        expect_v("conflict_pulse", 32'd1);
        tick();
        compare({31'd0, bus.write_conflict});
        idle();
        expect_v("conflict_clear", 32'd0);
        tick();
        compare({31'd0, bus.write_conflict});
        read_chk("conflict_mscratch", 12'h340, 32'd0, 1'b0);
        read_chk("conflict_mepc", 12'h341, 32'h0000_0100, 1'b0);

        instr_write(12'h340, 32'h1234_5678);
        read_chk("mscratch_rw", 12'h340, 32'h1234_5678, 1'b0);
        expect_v("normal_write_wc", 32'd0);
        compare({31'd0, bus.write_conflict});

        // Illegal accesses and masked fields
        read_chk("unimpl_7c0", 12'h7C0, 32'd0, 1'b1);
        bus.csr_read_address  = 12'h300;
        bus.trap_done         = 1'b1;
        bus.csr_write_enable  = 1'b1;
        bus.csr_write_address = 12'h301;
        bus.csr_write_data    = 32'hFFFF_FFFF;
        #1;
        expect_v("misa_write_ill", 32'd1);
        compare({31'd0, bus.csr_illegal});
        tick();
        bus.csr_write_enable = 1'b0;
        read_chk("misa_kept", 12'h301, 32'h4000_0100, 1'b0);
        instr_write(12'h305, 32'h0000_1003);
        read_chk("mtvec_mask", 12'h305, 32'h0000_1000, 1'b0);
        instr_write(12'h300, 32'hFFFF_FFFF);
        read_chk("mstatus_mask", 12'h300, 32'h0000_1888, 1'b0);
        read_chk("mhartid", 12'hF14, P_HART_ID, 1'b0);
        read_chk("mimpid", 12'hF13, 32'h0000_0001, 1'b0);
        read_chk("mip", 12'h344, 32'd0, 1'b0);
        instr_write(12'h343, 32'hA5A5_0F0F);
        read_chk("mtval_rw", 12'h343, 32'hA5A5_0F0F, 1'b0);

`ifdef CSR_COUNTERS_EN
        // Low-half overflow must carry into the high half
        instr_write(12'hB80, 32'd5);
        instr_write(12'hB00, 32'hFFFF_FFFF);
        tick();
        tick();
        read_chk("mcycle_lo_carry", 12'hB00, 32'd1, 1'b0);
        read_chk("mcycle_hi_carry", 12'hB80, 32'd6, 1'b0);
        bus.trap_done         = 1'b1;
        bus.csr_write_enable  = 1'b1;
        bus.csr_write_address = 12'hC00;
        bus.csr_read_address  = 12'h300;
        #1;
        expect_v("cycle_shadow_write_ill", 32'd1);
        compare({31'd0, bus.csr_illegal});
        tick();
        bus.csr_write_enable = 1'b0;
        bus.instruction_retired = 1'b1;
        instr_write(12'hB02, 32'd0);
        tick();
        tick();
        tick();
        bus.instruction_retired = 1'b0;
        read_chk("instret_shadow", 12'hC02, 32'd3, 1'b0);
        read_chk("minstret_hi", 12'hB82, 32'd0, 1'b0);
`else
        bus.instruction_retired = 1'b1;
        tick();
        bus.instruction_retired = 1'b0;
        read_chk("no_mcycle", 12'hB00, 32'd0, 1'b1);
        read_chk("no_instret_h", 12'hC82, 32'd0, 1'b1);
        instr_write(12'hB02, 32'd7);
        read_chk("no_minstret", 12'hB02, 32'd0, 1'b1);
`endif

        // Reset in the middle of a trap sequence, with a conflict pulse outstanding
        bus.trap_done           = 1'b0;
        bus.csr_trap_address    = 12'h342;
        bus.csr_trap_write_data = 32'd7;
        bus.csr_write_enable    = 1'b1;
        bus.csr_write_address   = 12'h340;
        bus.csr_write_data      = 32'd0;
        tick();
        bus.csr_write_enable    = 1'b0;
        bus.csr_trap_address    = 12'h341;
        bus.csr_trap_write_data = 32'h0000_0044;
        #1;
        expect_v("pre_rst_wc", 32'd1);
        compare({31'd0, bus.write_conflict});
        expect_v("pre_rst_mepc", 32'h0000_0100);
        compare(bus.csr_read_data);
        rst = 1'b1;
        #1;
        expect_v("rst_mid_mepc", 32'd0);
        compare(bus.csr_read_data);
        expect_v("rst_mid_wc", 32'd0);
        compare({31'd0, bus.write_conflict});
        bus.csr_trap_address = 12'h342;
        #1;
        expect_v("rst_mid_mcause", 32'd0);
        compare(bus.csr_read_data);
        bus.csr_trap_address = 12'h305;
        #1;
        expect_v("rst_mid_mtvec", MTVEC_EXP);
        compare(bus.csr_read_data);
        bus.csr_trap_address = 12'h341;
        tick();
        expect_v("rst_held_mepc", 32'd0);
        compare(bus.csr_read_data);
        @(negedge clk);
        rst = 1'b0;
        idle();
        tick();

        if (sb_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_leftover: observed %0d pending required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
